// File: rtl/bus_driver_arbiter.sv
// Round-robin owner selection for the shared W-bus, with break-before-make dead time.
// Ports:
//   CLK    - system clock, rising edge
//   CLR_N  - asynchronous active-low reset
//   REQ    - level requests, one bit per source
//   GNT    - one-hot grant to the current owner (zero when no owner)
//   OE     - tri-state enables, identical to GNT, high only while driving
//   OWNER  - index of the current or most recent owner
//   BUSY   - high while driving or in the dead-time window
module bus_driver_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned MAX_HOLD    = 8,
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic [N-1:0]  OE,
  output logic [OW-1:0] OWNER,
  output logic          BUSY
);

  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned TW = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_TURN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic          busy_q, busy_d;

  logic          win_found;
  logic [OW-1:0] win_idx;
  logic [OW-1:0] cand;
  logic          release_c;

  // First requester at or after the priority pointer, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = OW'((32'(ptr_q) + 32'(k)) % N);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Owner dropping its request and hitting the hold limit collapse into one release.
  assign release_c = !REQ[owner_q] ||
                     ((MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD)));

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (win_found) begin
          state_d = S_DRIVE;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
          hold_d  = HW'(1);
          busy_d  = 1'b1;
        end
      end
      S_DRIVE: begin
        if (release_c) begin
          state_d = S_TURN;
          gnt_d   = '0;
          ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
          turn_d  = TW'(1);
        end else if (hold_q != '1) begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_TURN: begin
        gnt_d = '0;
        if (turn_q == TW'(TURN_CYCLES)) begin
          state_d = S_IDLE;
          turn_d  = '0;
          busy_d  = 1'b0;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears the bus immediately.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT   = gnt_q;
  assign OE    = gnt_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_bus_driver_arbiter.sv
// Scoreboard bench for bus_driver_arbiter: two instances (TURN=1/HOLD=8 and TURN=3/HOLD=5)
// share REQ and CLR_N; a per-edge reference model queues expected outputs, and negedge
// monitors pop and compare them and check the enable invariants.
module tb_bus_driver_arbiter;

  localparam int NREQ = 4;

  logic       CLK;
  logic       CLR_N;
  logic [3:0] REQ;
  logic [3:0] gnt_a, oe_a, gnt_b, oe_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  bus_driver_arbiter #(.N(4), .TURN_CYCLES(1), .MAX_HOLD(8)) dut_a (
    .CLK(CLK), .CLR_N(CLR_N), .REQ(REQ),
    .GNT(gnt_a), .OE(oe_a), .OWNER(owner_a), .BUSY(busy_a));

  bus_driver_arbiter #(.N(4), .TURN_CYCLES(3), .MAX_HOLD(5)) dut_b (
    .CLK(CLK), .CLR_N(CLR_N), .REQ(REQ),
    .GNT(gnt_b), .OE(oe_b), .OWNER(owner_b), .BUSY(busy_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: who drives, for how long so far, and how many dead cycles remain.
  typedef struct {
    bit drv;
    int owner;
    int ptr;
    int cnt;
    int dead;
  } mstate_t;

  typedef struct {
    int oe;
    int owner;
    int busy;
  } exp_t;

  mstate_t ms_a, ms_b;
  exp_t    q_a[$];
  exp_t    q_b[$];

  function automatic mstate_t m_reset();
    mstate_t s;
    s.drv = 1'b0; s.owner = 0; s.ptr = 0; s.cnt = 0; s.dead = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(mstate_t s, logic [3:0] req, int turn, int maxh);
    mstate_t n = s;
    bit found = 1'b0;
    if (s.drv) begin
      if (!req[s.owner] || (maxh != 0 && s.cnt == maxh)) begin
        n.drv  = 1'b0;
        n.ptr  = (s.owner + 1) % NREQ;
        n.dead = turn;
      end else begin
        n.cnt = s.cnt + 1;
      end
    end else if (s.dead > 0) begin
      n.dead = s.dead - 1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (s.ptr + k) % NREQ;
        if (!found && req[c]) begin
          found   = 1'b1;
          n.drv   = 1'b1;
          n.owner = c;
          n.cnt   = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic exp_t m_out(mstate_t s);
    exp_t e;
    e.oe    = s.drv ? (1 << s.owner) : 0;
    e.owner = s.owner;
    e.busy  = (s.drv || s.dead > 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply r before the next rising edge, then advance the model for that edge.
  task automatic cycle(input logic [3:0] r);
    REQ = r;
    @(posedge CLK);
    #1;
    if (!CLR_N) begin
      ms_a = m_reset();
      ms_b = m_reset();
    end else begin
      ms_a = m_step(ms_a, REQ, 1, 8);
      ms_b = m_step(ms_b, REQ, 3, 5);
    end
    q_a.push_back(m_out(ms_a));
    q_b.push_back(m_out(ms_b));
  endtask

  logic [3:0] prev_a = 4'd0;
  logic [3:0] prev_b = 4'd0;

  always @(negedge CLK) begin
    exp_t e;
    if (!CLR_N) begin
      if (q_a.size() > 0) void'(q_a.pop_front());
      chk("a_rst_oe", int'(oe_a), 0);
      chk("a_rst_owner", int'(owner_a), 0);
      chk("a_rst_busy", int'(busy_a), 0);
    end else if (q_a.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL a_queue: got empty expected entry at %0t", $time);
    end else begin
      e = q_a.pop_front();
      chk("a_oe", int'(oe_a), e.oe);
      chk("a_owner", int'(owner_a), e.owner);
      chk("a_busy", int'(busy_a), e.busy);
    end
    chk("a_gnt_eq_oe", int'(gnt_a), int'(oe_a));
    chk("a_onehot0", int'($onehot0(oe_a)), 1);
    chk("a_no_handover", int'(prev_a != 0 && oe_a != 0 && oe_a != prev_a), 0);
    prev_a = oe_a;
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!CLR_N) begin
      if (q_b.size() > 0) void'(q_b.pop_front());
      chk("b_rst_oe", int'(oe_b), 0);
      chk("b_rst_owner", int'(owner_b), 0);
      chk("b_rst_busy", int'(busy_b), 0);
    end else if (q_b.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL b_queue: got empty expected entry at %0t", $time);
    end else begin
      e = q_b.pop_front();
      chk("b_oe", int'(oe_b), e.oe);
      chk("b_owner", int'(owner_b), e.owner);
      chk("b_busy", int'(busy_b), e.busy);
    end
    chk("b_gnt_eq_oe", int'(gnt_b), int'(oe_b));
    chk("b_onehot0", int'($onehot0(oe_b)), 1);
    chk("b_no_handover", int'(prev_b != 0 && oe_b != 0 && oe_b != prev_b), 0);
    prev_b = oe_b;
  end

  initial begin
    logic [3:0] r;
    ms_a  = m_reset();
    ms_b  = m_reset();
    CLR_N = 1'b0;
    REQ   = 4'd0;
    cycle(4'd0);
    cycle(4'd0);
    CLR_N = 1'b1;

    // Single request of 3 cycles.
    repeat (3) cycle(4'b0001);
    repeat (6) cycle(4'b0000);

    // All requesting: round-robin with forced releases.
    repeat (48) cycle(4'b1111);
    repeat (6) cycle(4'b0000);

    // Sole requester held past the hold limit.
    repeat (20) cycle(4'b0100);
    repeat (6) cycle(4'b0000);

    // Pointer wrap: owner 3 releases, then 0 and 3 compete.
    repeat (3) cycle(4'b1000);
    repeat (6) cycle(4'b0000);
    repeat (26) cycle(4'b1001);
    repeat (6) cycle(4'b0000);

    // Dead-time between two competing sources.
    repeat (20) cycle(4'b0011);
    repeat (6) cycle(4'b0000);

    // Asynchronous reset while source 1 drives.
    repeat (4) cycle(4'b0010);
    chk("pre_rst_oe_a", int'(oe_a), 2);
    #1;
    CLR_N = 1'b0;
    #1;
    chk("async_oe_a", int'(oe_a), 0);
    chk("async_gnt_a", int'(gnt_a), 0);
    chk("async_busy_a", int'(busy_a), 0);
    chk("async_oe_b", int'(oe_b), 0);
    chk("async_busy_b", int'(busy_b), 0);
    cycle(4'b0000);
    cycle(4'b0000);
    CLR_N = 1'b1;
    repeat (5) cycle(4'b0011);
    repeat (8) cycle(4'b0000);

    // Randomized request traffic.
    r = 4'd0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cycle(r);
    end
    repeat (10) cycle(4'b0000);

    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
